seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream stage between the free-running counter/value logic and the 4-digit common-cathode seven-segment display on the UPduino board.
- Takes a 16-bit hex value plus per-digit decimal points and time-multiplexes them onto SEG/COMM.
- Adds a per-digit blanking gap to prevent ghosting.
- Snapshots the value once per frame so the display never tears.

Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz.
- DIGIT_HZ, 1000, digit-slot rate in Hz. Slot length DIV = CLK_HZ/DIGIT_HZ cycles; a frame is 4 slots.
- BLANK_CYCLES, 120, cycles at the start of each slot with all digits off. Must satisfy 1 <= BLANK_CYCLES < DIV; otherwise elaboration fails via generate-time error.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  reset, asynchronous, active-low.
- VALUE  input  16  hex value; nibble k shows on digit k (digit 0 = rightmost).
- DP_IN  input  4  decimal point request per digit, active high.
- EN  input  1  display enable; low blanks the outputs.
- SEG  output  7  segments, active high; SEG[0]=a … SEG[6]=g.
- DP  output  1  decimal point segment, active high.
- COMM  output  4  common cathodes, active low; COMM[k] = digit k.
- FRAME_TICK  output  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (RST_N low, takes effect immediately, independent of CLK):
  - Outputs: SEG=0, DP=0, COMM=4'b1111, FRAME_TICK=0.
  - Internal state: slot counter=0, digit index=0, snapshot value/DP=0, phase=BLANK.
- Slot counter counts 0..DIV-1, then wraps to 0.
- On wrap, digit index advances 0→1→2→3→0.
- Phase state machine:
  - BLANK while slot count < BLANK_CYCLES.
  - DRIVE otherwise.
  - Transitions BLANK→DRIVE at count==BLANK_CYCLES and DRIVE→BLANK on wrap.
- Frame start is the cycle where the slot counter wraps and the digit index goes 3→0. On that cycle:
  - VALUE and DP_IN are captured into the snapshot.
  - FRAME_TICK is registered high for exactly one cycle.
- The first frame after reset displays snapshot 0 until the first capture.
- All outputs are registered: they reflect the phase/digit state with one cycle of latency.
- In DRIVE for digit k:
  - COMM has only bit k low.
  - SEG = hex decode of snapshot nibble k.
  - DP = snapshot DP bit k.
- In BLANK: COMM=1111, SEG=0, DP=0.
- At most one COMM bit is low on any cycle, including at slot edges.
- Hex decode (bits g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- EN low:
  - Next registered outputs are forced to the BLANK values.
  - Counters, snapshot capture and FRAME_TICK continue unaffected.
  - EN rising resumes mid-slot according to the current phase.
- VALUE changes between frame starts have no visible effect until the next frame start.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k>0) is suppressed when all snapshot nibbles k..3 are zero. Suppressed means COMM[k] stays high during its DRIVE phase.
  - A suppressed digit is still shown if its DP bit is set; SEG=0 in that case.
  - Digit 0 is always shown.
  - The suppression mask is computed from the snapshot at capture.
- Undefined: all four digits are always driven.

Decomposition:
- Package seg7_pkg holds:
  - The 16-entry hex-to-segment constant table.
  - The phase enum (BLANK, DRIVE).
  - The COMM_OFF=4'b1111 constant.
  - A function computing DIV.
- Sub-module seg7_hex_decode is purely combinational: 4-bit nibble in, 7-bit segments out, using the package table.
- Counters, FSM, snapshot and output registers live in seg7_scan_driver.

Test Plan:
All scenarios use CLK_HZ=1000, DIGIT_HZ=100 (DIV=10) and BLANK_CYCLES=2.
- Reset mid-DRIVE: drop RST_N between clock edges → COMM=1111, SEG=0, DP=0 before the next edge; after release, first FRAME_TICK 40 cycles later.
- VALUE=16'h1234, DP_IN=0, EN=1, after one frame:
  - Digit 0 slot: COMM=1110, SEG=1100110 for 8 cycles after 2 blank cycles.
  - Digit 3 slot: COMM=0111, SEG=0000110.
- Tear check: change VALUE from 16'h1234 to 16'hABCD during digit 1 slot → digits 2,3 still show 2,1. After the next FRAME_TICK, digit 0 shows 1011110 (d).
- EN low for 15 cycles mid-frame:
  - COMM=1111 from one cycle after EN falls.
  - FRAME_TICK period stays 40 cycles.
  - Display resumes correctly on the correct digit.
- Ghosting: run 3 frames and monitor every cycle → popcount(~COMM) ≤ 1 always, and COMM=1111 for exactly 2 cycles at each slot start.
- VALUE=16'h0042, DP_IN=4'b1000:
  - With SEG7_LZB_EN: COMM[2] never low; COMM[3] low with SEG=0, DP=1.
  - Without the macro: digit 2 shows 0111111.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment table,
// scan phase type, digit-off constant and slot-length helper.
// Optional build macro used by the driver: SEG7_LZB_EN (leading-zero blanking).
package seg7_pkg;

    // All common cathodes released (active-low, so every digit dark).
    localparam logic [3:0] COMM_OFF = 4'b1111;

    // Scan phase within one digit slot.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_e;

    // Hex digit to segment pattern, bit order g..a (bit 0 = segment a).
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'b0111111, // 0
        7'b0000110, // 1
        7'b1011011, // 2
        7'b1001111, // 3
        7'b1100110, // 4
        7'b1101101, // 5
        7'b1111101, // 6
        7'b0000111, // 7
        7'b1111111, // 8
        7'b1101111, // 9
        7'b1110111, // A
        7'b1111100, // b
        7'b0111001, // C
        7'b1011110, // d
        7'b1111001, // E
        7'b1110001  // F
    };

    // Number of clock cycles in one digit slot.
    function automatic int seg7_div(input int clk_hz, input int digit_hz);
        return clk_hz / digit_hz;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Look up the segment pattern for the nibble in the shared table.
    always_comb begin
        seg = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-cathode seven-segment scan driver.
// Each digit slot starts with a blanking gap (anti-ghosting), then drives
// one digit. The displayed value is snapshotted once per frame so a digit
// sequence never tears. All outputs are registered.
// Build macro SEG7_LZB_EN enables leading-zero blanking of digits 1..3.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 12000000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 120
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] VALUE,
    input  logic [3:0]  DP_IN,
    input  logic        EN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  COMM,
    output logic        FRAME_TICK
);

    localparam int DIV   = seg7_div(CLK_HZ, DIGIT_HZ);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    // The blanking gap must leave at least one drive cycle per slot.
    generate
        if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= DIV)) begin : g_bad_blank
            $error("seg7_scan_driver: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < CLK_HZ/DIGIT_HZ");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    phase_e           phase_q, phase_d;
    logic [15:0]      snap_value_q, snap_value_d;
    logic [3:0]       snap_dp_q, snap_dp_d;
    logic [3:0]       supp_q, supp_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       comm_q, comm_d;
    logic             tick_q, tick_d;

    logic             wrap_s;
    logic             frame_start_s;
    logic [3:0]       cur_nib_s;
    logic [6:0]       cur_seg_s;

    seg7_hex_decode u_dec (
        .nibble (cur_nib_s),
        .seg    (cur_seg_s)
    );

    // Pick the snapshot nibble belonging to the digit currently scanned.
    always_comb begin
        cur_nib_s = 4'h0;
        case (digit_q)
            2'd0:    cur_nib_s = snap_value_q[3:0];
            2'd1:    cur_nib_s = snap_value_q[7:4];
            2'd2:    cur_nib_s = snap_value_q[11:8];
            2'd3:    cur_nib_s = snap_value_q[15:12];
            default: cur_nib_s = 4'h0;
        endcase
    end

    // Slot counter, digit index and blank/drive phase sequencing.
    always_comb begin
        wrap_s        = (cnt_q == CNT_W'(DIV - 1));
        frame_start_s = wrap_s && (digit_q == 2'd3);
        if (wrap_s) begin
            cnt_d   = {CNT_W{1'b0}};
            digit_d = digit_q + 2'd1;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            digit_d = digit_q;
        end
        // Phase mirrors the next count so it flips exactly at BLANK_CYCLES and at wrap.
        if (cnt_d < CNT_W'(BLANK_CYCLES)) begin
            phase_d = BLANK;
        end else begin
            phase_d = DRIVE;
        end
    end

    // Frame-start snapshot of value, decimal points and zero-suppression mask.
    always_comb begin
        tick_d = frame_start_s;
        if (frame_start_s) begin
            snap_value_d = VALUE;
            snap_dp_d    = DP_IN;
`ifdef SEG7_LZB_EN
            supp_d[0] = 1'b0;
            supp_d[1] = (VALUE[15:4]  == 12'h000);
            supp_d[2] = (VALUE[15:8]  == 8'h00);
            supp_d[3] = (VALUE[15:12] == 4'h0);
`else
            supp_d    = 4'b0000;
`endif
        end else begin
            snap_value_d = snap_value_q;
            snap_dp_d    = snap_dp_q;
            supp_d       = supp_q;
        end
    end

    // Next output pattern from the current phase/digit; EN low forces blank.
    always_comb begin
        comm_d = COMM_OFF;
        seg_d  = 7'b0000000;
        dp_d   = 1'b0;
        if (EN && (phase_q == DRIVE)) begin
            if (!supp_q[digit_q]) begin
                comm_d = COMM_OFF & ~(4'b0001 << digit_q);
                seg_d  = cur_seg_s;
                dp_d   = snap_dp_q[digit_q];
            end else if (snap_dp_q[digit_q]) begin
                // Suppressed leading zero that still carries a decimal point.
                comm_d = COMM_OFF & ~(4'b0001 << digit_q);
                seg_d  = 7'b0000000;
                dp_d   = 1'b1;
            end else begin
                comm_d = COMM_OFF;
                seg_d  = 7'b0000000;
                dp_d   = 1'b0;
            end
        end else begin
            comm_d = COMM_OFF;
            seg_d  = 7'b0000000;
            dp_d   = 1'b0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q        <= {CNT_W{1'b0}};
            digit_q      <= 2'd0;
            phase_q      <= BLANK;
            snap_value_q <= 16'h0000;
            snap_dp_q    <= 4'b0000;
`ifdef SEG7_LZB_EN
            supp_q       <= 4'b1110;
`else
            supp_q       <= 4'b0000;
`endif
            seg_q        <= 7'b0000000;
            dp_q         <= 1'b0;
            comm_q       <= COMM_OFF;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            phase_q      <= phase_d;
            snap_value_q <= snap_value_d;
            snap_dp_q    <= snap_dp_d;
            supp_q       <= supp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            comm_q       <= comm_d;
            tick_q       <= tick_d;
        end
    end

    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign COMM       = comm_q;
    assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIV=10, 2 blank cycles).
module tb_seg7_scan_driver;

    logic        CLK;
    logic        RST_N;
    logic [15:0] VALUE;
    logic [3:0]  DP_IN;
    logic        EN;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  COMM;
    logic        FRAME_TICK;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_driver #(
        .CLK_HZ       (1000),
        .DIGIT_HZ     (100),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .VALUE      (VALUE),
        .DP_IN      (DP_IN),
        .EN         (EN),
        .SEG        (SEG),
        .DP         (DP),
        .COMM       (COMM),
        .FRAME_TICK (FRAME_TICK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hand-written segment patterns (g..a).
    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            4'hF: return 7'b1110001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // After reset release: count edges to the first FRAME_TICK (bounded).
    task automatic wait_first_tick(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (n == 5) begin
                chk({tag, "_first_frame_comm"}, {12'h000, COMM}, 16'h000E);
                chk({tag, "_first_frame_seg0"}, {9'h000, SEG}, 16'h003F);
            end
            if (FRAME_TICK === 1'b1) break;
        end
        chk({tag, "_first_tick_latency"}, 16'(n), 16'd40);
    endtask

    // Check one whole frame, cycle by cycle, from just after a FRAME_TICK
    // cycle up to and including the next FRAME_TICK cycle.
    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] dp,
                               input int chg_j, input logic [15:0] chg_v, input int en_s);
        int         k;
        int         c;
        logic       drive;
        logic       sup;
        logic [3:0] e_comm;
        logic [6:0] e_seg;
        logic       e_dp;
        for (int j = 1; j <= 40; j++) begin
            step();
            k = (j - 1) / 10;
            c = (j - 1) % 10;
            drive = (c >= 2) && !((en_s >= 0) && (j > en_s) && (j <= en_s + 15));
            e_comm = 4'b1111;
            e_seg  = 7'b0000000;
            e_dp   = 1'b0;
`ifdef SEG7_LZB_EN
            sup = (k > 0) && ((v >> (4 * k)) == 16'h0000);
`else
            sup = 1'b0;
`endif
            if (drive && (!sup || dp[k])) begin
                e_comm = 4'b1111 & ~(4'b0001 << k);
                e_seg  = sup ? 7'b0000000 : hexseg(v[4*k +: 4]);
                e_dp   = dp[k];
            end
            chk($sformatf("%s_comm_j%0d", tag, j), {12'h000, COMM}, {12'h000, e_comm});
            chk($sformatf("%s_seg_j%0d", tag, j), {9'h000, SEG}, {9'h000, e_seg});
            chk($sformatf("%s_dp_j%0d", tag, j), {15'h0000, DP}, {15'h0000, e_dp});
            chk($sformatf("%s_tick_j%0d", tag, j), {15'h0000, FRAME_TICK}, {15'h0000, (j == 40)});
            chk($sformatf("%s_onehot_j%0d", tag, j), {15'h0000, ($countones(~COMM) <= 1)}, 16'h0001);
            if (j == chg_j) VALUE = chg_v;
            if ((en_s >= 0) && (j == en_s)) EN = 1'b0;
            if ((en_s >= 0) && (j == en_s + 15)) EN = 1'b1;
        end
    endtask

    initial begin
        RST_N = 1'b0;
        VALUE = 16'h1234;
        DP_IN = 4'b0000;
        EN    = 1'b1;

        // Reset state.
        step();
        step();
        step();
        chk("rst_comm", {12'h000, COMM}, 16'h000F);
        chk("rst_seg", {9'h000, SEG}, 16'h0000);
        chk("rst_dp", {15'h0000, DP}, 16'h0000);
        chk("rst_tick", {15'h0000, FRAME_TICK}, 16'h0000);

        RST_N = 1'b1;
        wait_first_tick("rel1");

        // 1234 displayed; value changes mid-frame must not tear.
        check_frame("f1234", 16'h1234, 4'b0000, -1, 16'h0000, -1);
        check_frame("tear", 16'h1234, 4'b0000, 15, 16'hABCD, -1);

        // EN low for 15 cycles mid-frame.
        check_frame("en_gap", 16'hABCD, 4'b0000, -1, 16'h0000, 14);

        // Ghosting: three frames monitored every cycle.
        VALUE = 16'h5F80;
        DP_IN = 4'b0101;
        check_frame("ghost0", 16'hABCD, 4'b0000, -1, 16'h0000, -1);
        check_frame("ghost1", 16'h5F80, 4'b0101, -1, 16'h0000, -1);
        VALUE = 16'h0042;
        DP_IN = 4'b1000;
        check_frame("ghost2", 16'h5F80, 4'b0101, -1, 16'h0000, -1);

        // Leading zeros with a decimal point on digit 3.
        check_frame("lz0042", 16'h0042, 4'b1000, -1, 16'h0000, -1);

        // Reset asserted in the middle of a DRIVE cycle.
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_comm", {12'h000, COMM}, 16'h000E);
        chk("pre_rst_seg", {9'h000, SEG}, {9'h000, 7'b1011011});
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_comm", {12'h000, COMM}, 16'h000F);
        chk("async_rst_seg", {9'h000, SEG}, 16'h0000);
        chk("async_rst_dp", {15'h0000, DP}, 16'h0000);
        step();
        RST_N = 1'b1;
        wait_first_tick("rel2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
